// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - opcode constants and FSM state encoding shared by the ALU execution unit
package alu_exec_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b00111;
    localparam logic [4:0] OP_SRL  = 5'b01000;
    localparam logic [4:0] OP_SRA  = 5'b01001;
    localparam logic [4:0] OP_SLT  = 5'b01010;
    localparam logic [4:0] OP_SLTU = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_iter_mul.sv
// rtl/alu_iter_mul.sv - shift-add multiplier, one multiplier bit per cycle, low XLEN bits of product
module alu_iter_mul #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            run;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= src1;
            mplier <= src2;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run && (cnt != CW'(XLEN))) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // Finished once every multiplier bit has been consumed
    always_comb begin
        done    = run && (cnt == CW'(XLEN));
        product = acc;
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// rtl/alu_exec_pipe.sv - single-issue ALU with held result; multiplier built only with ALU_EXEC_MUL_EN
module alu_exec_pipe
    import alu_exec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_opcode,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [XLEN-1:0]  src1_data,
    input  logic [XLEN-1:0]  src2_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [XLEN-1:0]  result_data,
    output logic [TAG_W-1:0] result_tag,
    output logic             result_illegal,
    output logic             busy
);
    localparam int SHW = $clog2(XLEN);

    alu_state_e      state;
    alu_state_e      state_nxt;
    logic            accept;
    logic            op_is_mul;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [SHW-1:0]  shamt;

`ifdef ALU_EXEC_MUL_EN
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign op_is_mul = (issue_opcode == OP_MUL);

    alu_iter_mul #(
        .XLEN(XLEN)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && op_is_mul),
        .src1    (src1_data),
        .src2    (src2_data),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign op_is_mul = 1'b0;
`endif

    assign shamt = src2_data[SHW-1:0];

    // Single-cycle datapath; anything not decoded here (including MUL when it is not built) is illegal
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (issue_opcode)
            OP_ADD:  alu_res = src1_data + src2_data;
            OP_SUB:  alu_res = src1_data - src2_data;
`ifdef ALU_EXEC_MUL_EN
            OP_MUL:  alu_res = '0;
`endif
            OP_AND:  alu_res = src1_data & src2_data;
            OP_OR:   alu_res = src1_data | src2_data;
            OP_XOR:  alu_res = src1_data ^ src2_data;
            OP_SLL:  alu_res = src1_data << shamt;
            OP_SRL:  alu_res = src1_data >> shamt;
            OP_SRA:  alu_res = $signed(src1_data) >>> shamt;
            OP_SLT:  alu_res = XLEN'($signed(src1_data) < $signed(src2_data));
            OP_SLTU: alu_res = XLEN'(src1_data < src2_data);
            default: alu_ill = 1'b1;
        endcase
    end

    // Next state and handshake: a held result must be consumed before a new issue is taken
    always_comb begin
        state_nxt   = state;
        issue_ready = (state == ST_IDLE) || ((state == ST_DONE) && result_ready);
        accept      = issue_valid && issue_ready;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = op_is_mul ? ST_MUL : ST_DONE;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (accept) begin
                    state_nxt = op_is_mul ? ST_MUL : ST_DONE;
                end else if (result_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result payload: written only at accept or multiplier completion, so it holds under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            result_data    <= '0;
            result_tag     <= '0;
            result_illegal <= 1'b0;
        end else if (accept) begin
            result_data    <= alu_res;
            result_tag     <= issue_tag;
            result_illegal <= alu_ill;
        end
`ifdef ALU_EXEC_MUL_EN
        else if ((state == ST_MUL) && mul_done) begin
            result_data <= mul_product;
        end
`endif
    end

    assign result_valid = (state == ST_DONE);
    assign busy         = (state != ST_IDLE);

endmodule

// File: doc/alu_exec_pipe.md
ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width (power of two, 8..64).
REQ-002 SHALL have parameter TAG_W, default 6: width of the instruction tag carried with each operation.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port issue_valid, input, 1: issue request present.
REQ-006 SHALL have port issue_ready, output, 1: unit accepts the issue this cycle.
REQ-007 SHALL have port issue_opcode, input, 5: operation select.
REQ-008 SHALL have port issue_tag, input, TAG_W: tag returned with the result.
REQ-009 SHALL have ports src1_data and src2_data, input, XLEN: operands.
REQ-010 SHALL have port result_valid, output, 1: result held for consumer.
REQ-011 SHALL have port result_ready, input, 1: consumer takes the result this cycle.
REQ-012 SHALL have ports result_data (XLEN), result_tag (TAG_W), result_illegal (1), outputs: result payload.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL accept an issue when issue_valid and issue_ready are both high at a rising edge.
REQ-015 SHALL drive issue_ready = (state==IDLE) or (state==DONE and result_ready); no other state accepts.
REQ-016 SHALL implement FSM states IDLE, MUL, DONE: IDLE/DONE accept of non-MUL op -> DONE; accept of MUL -> MUL; MUL after XLEN iterations -> DONE; DONE with result_ready and no accept -> IDLE.
REQ-017 SHALL decode opcodes: 00001 ADD, 00010 SUB, 00011 MUL, 00100 AND, 00101 OR, 00110 XOR, 00111 SLL, 01000 SRL, 01001 SRA, 01010 SLT (signed), 01011 SLTU.
REQ-018 SHALL produce non-MUL results with latency 1: result_valid high the cycle after accept.
REQ-019 SHALL compute MUL as low XLEN bits of src1*src2 by iterative shift-add, one bit per cycle, result_valid exactly XLEN+1 cycles after accept.
REQ-020 SHALL wrap ADD/SUB/MUL modulo 2^XLEN; no overflow flag.
REQ-021 SHALL use src2_data[log2(XLEN)-1:0] as shift amount, upper bits ignored.
REQ-022 SHALL return SLT/SLTU as zero-extended 0 or 1.
REQ-023 SHALL, for undefined opcodes (incl. 00000), return result_data=0, result_illegal=1, latency 1; result_illegal=0 otherwise.
REQ-024 SHALL hold result_data, result_tag, result_illegal stable while result_valid is high and result_ready low (backpressure).
REQ-025 SHALL on simultaneous result_ready and accept in DONE, replace the payload in the same edge with no bubble.
REQ-026 SHALL latch operands at accept; operand changes during MUL have no effect.
REQ-027 SHALL ignore issue_valid when issue_ready is low (no queuing).

Reset
REQ-028 SHALL on reset force state IDLE, result_valid=0, result_data=0, result_tag=0, result_illegal=0, busy=0, multiplier counter 0.
REQ-029 SHALL abort an in-flight MUL on reset mid-operation; no result is emitted for it.
REQ-030 SHALL drive issue_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-031 SHALL, with macro ALU_EXEC_MUL_EN defined, implement MUL per REQ-019.
REQ-032 SHALL, with ALU_EXEC_MUL_EN undefined, omit the multiplier and MUL state; opcode 00011 treated as illegal per REQ-023.

Structure
REQ-033 SHALL place opcode constants and FSM state encoding in shared package alu_exec_pkg.
REQ-034 SHALL implement the multiplier as sub-module alu_iter_mul (start, operands, done, product), instantiated only under ALU_EXEC_MUL_EN.

Verification
REQ-035 ADD 0xFFFFFFFF+0x00000001, tag 5 -> next cycle result_valid=1, result_data=0, result_tag=5.
REQ-036 MUL 0x00010003*0x00000007, ready held high -> result 0x00070015 exactly 33 cycles after accept, busy high throughout.
REQ-037 SRA 0x80000000 by src2=0x00000024 -> shift 4, result 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-038 Opcode 11111 -> result_data=0, result_illegal=1; MUL with ALU_EXEC_MUL_EN undefined -> same.
REQ-039 result_ready low 3 cycles -> payload stable, issue_ready low; ready high with new issue -> back-to-back results, no bubble.
REQ-040 reset asserted 10 cycles into a MUL -> next cycle IDLE, result_valid=0, no stale result after reset release.
